// File: rtl/mips_multicycle_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : mips_multicycle_ctrl_if
// Purpose  : Request/ready handshake between the multi-cycle MIPS sequencing
//            controller and the shared instruction/data memory.
// Signals  : mem_req   - memory access request (controller -> memory)
//            mem_we    - write access, meaningful only with mem_req
//            iord      - address select: 0 = PC, 1 = ALUOut
//            mem_ready - memory completes the current access this cycle
// Revision : 1.0 - initial release
// ============================================================================
interface mips_multicycle_ctrl_if;
  logic mem_req;
  logic mem_we;
  logic iord;
  logic mem_ready;

  modport master (output mem_req, output mem_we, output iord, input mem_ready);
  modport slave  (input mem_req, input mem_we, input iord, output mem_ready);
endinterface
`default_nettype wire

// File: rtl/mips_multicycle_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mips_multicycle_ctrl
// Purpose  : Moore sequencing controller for a multi-cycle MIPS datapath with
//            one shared memory, an IR and a single reused ALU. Steps each
//            instruction through fetch/decode/execute/memory/writeback,
//            counts retired instructions and traps on an illegal opcode or
//            a memory timeout.
// Ports    : clk, nrst (synchronous, active low)
//            opcode        - IR[31:26], valid from DECODE onward
//            mem           - memory handshake (mem_req/mem_we/iord/mem_ready)
//            ir_write, pc_write, pc_write_cond, branch_ne, pc_source,
//            alu_src_a, alu_src_b, alu_op, reg_write, reg_dst, mem_to_reg
//                          - datapath selects and enables
//            halted        - controller sits in TRAP
//            bus_error     - sticky memory timeout flag
//            illegal_op    - sticky unknown-opcode flag
//            instr_count   - retired-instruction counter (wraps)
//            state_dbg     - current state encoding
// Revision : 1.0 - initial release
// ============================================================================
module mips_multicycle_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned CNT_W       = 32
) (
  input  wire logic              clk,
  input  wire logic              nrst,
  input  wire logic [5:0]        opcode,
  mips_multicycle_ctrl_if.master mem,
  output logic                   ir_write,
  output logic                   pc_write,
  output logic                   pc_write_cond,
  output logic                   branch_ne,
  output logic [1:0]             pc_source,
  output logic                   alu_src_a,
  output logic [1:0]             alu_src_b,
  output logic [1:0]             alu_op,
  output logic                   reg_write,
  output logic [1:0]             reg_dst,
  output logic [1:0]             mem_to_reg,
  output logic                   halted,
  output logic                   bus_error,
  output logic                   illegal_op,
  output logic [CNT_W-1:0]       instr_count,
  output logic [3:0]             state_dbg
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_SLTI  = 6'b001010;

  // The wait counter only needs to reach MEM_TIMEOUT-1: the limit is hit on
  // the cycle where that value is present and mem_ready is still low.
  localparam int unsigned TW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

  typedef enum logic [3:0] {
    IDLE      = 4'd0,
    FETCH     = 4'd1,
    DECODE    = 4'd2,
    MEM_ADDR  = 4'd3,
    MEM_READ  = 4'd4,
    MEM_WB    = 4'd5,
    MEM_WRITE = 4'd6,
    EXEC_R    = 4'd7,
    WB_R      = 4'd8,
    EXEC_I    = 4'd9,
    WB_I      = 4'd10,
    BRANCH    = 4'd11,
    JUMP      = 4'd12,
    TRAP      = 4'd15
  } state_t;

  state_t        state;
  state_t        next_state;
  logic [TW-1:0] tmo_cnt;
  logic          wait_state;
  logic          tmo_hit;
  logic          retire;
  logic          illegal_set;
  logic          mem_req_c;
  logic          mem_we_c;
  logic          iord_c;

  assign wait_state = (state == FETCH) || (state == MEM_READ) || (state == MEM_WRITE);
  // A mem_ready arriving on the limit cycle completes the access normally.
  assign tmo_hit    = (MEM_TIMEOUT != 0) && wait_state && !mem.mem_ready && (tmo_cnt == TMO_LAST);

  assign mem.mem_req = mem_req_c;
  assign mem.mem_we  = mem_we_c;
  assign mem.iord    = iord_c;
  assign state_dbg   = state;

  // --------------------------------------------------------------------------
  // State, counters and sticky flags
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!nrst) begin
      state       <= IDLE;
      tmo_cnt     <= '0;
      instr_count <= '0;
      bus_error   <= 1'b0;
      illegal_op  <= 1'b0;
    end else begin
      state <= next_state;
      if (wait_state && !mem.mem_ready && !tmo_hit)
        tmo_cnt <= tmo_cnt + 1'b1;
      else
        tmo_cnt <= '0;
      if (retire)
        instr_count <= instr_count + 1'b1;
      if (tmo_hit)
        bus_error <= 1'b1;
      if (illegal_set)
        illegal_op <= 1'b1;
    end
  end

  // --------------------------------------------------------------------------
  // Next state and Moore outputs
  // --------------------------------------------------------------------------
  always_comb begin
    next_state    = state;
    mem_req_c     = 1'b0;
    mem_we_c      = 1'b0;
    iord_c        = 1'b0;
    ir_write      = 1'b0;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    branch_ne     = 1'b0;
    pc_source     = 2'b00;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    alu_op        = 2'b00;
    reg_write     = 1'b0;
    reg_dst       = 2'b00;
    mem_to_reg    = 2'b00;
    halted        = 1'b0;
    retire        = 1'b0;
    illegal_set   = 1'b0;

    case (state)
      IDLE: next_state = FETCH;

      FETCH: begin
        mem_req_c = 1'b1;
        alu_src_b = 2'b01;            // PC + 4
        ir_write  = mem.mem_ready;    // IR and PC update only when data arrives
        pc_write  = mem.mem_ready;
        if (mem.mem_ready) next_state = DECODE;
        else if (tmo_hit)  next_state = TRAP;
      end

      DECODE: begin
        alu_src_b = 2'b11;            // speculative branch target into ALUOut
        case (opcode)
          OP_RTYPE:                          next_state = EXEC_R;
          OP_LW, OP_SW:                      next_state = MEM_ADDR;
          OP_BEQ, OP_BNE:                    next_state = BRANCH;
          OP_J, OP_JAL:                      next_state = JUMP;
          OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: next_state = EXEC_I;
          default: begin
            next_state  = TRAP;
            illegal_set = 1'b1;
          end
        endcase
      end

      MEM_ADDR: begin
        alu_src_a  = 1'b1;
        alu_src_b  = 2'b10;
        next_state = (opcode == OP_SW) ? MEM_WRITE : MEM_READ;
      end

      MEM_READ: begin
        mem_req_c = 1'b1;
        iord_c    = 1'b1;
        if (mem.mem_ready) next_state = MEM_WB;
        else if (tmo_hit)  next_state = TRAP;
      end

      MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 2'b01;
        retire     = 1'b1;
        next_state = FETCH;
      end

      MEM_WRITE: begin
        mem_req_c = 1'b1;
        mem_we_c  = 1'b1;
        iord_c    = 1'b1;
        if (mem.mem_ready) begin
          retire     = 1'b1;
          next_state = FETCH;
        end else if (tmo_hit) begin
          next_state = TRAP;
        end
      end

      EXEC_R: begin
        alu_src_a  = 1'b1;
        alu_op     = 2'b10;
        next_state = WB_R;
      end

      WB_R: begin
        reg_write  = 1'b1;
        reg_dst    = 2'b01;
        retire     = 1'b1;
        next_state = FETCH;
      end

      EXEC_I: begin
        alu_src_a  = 1'b1;
        alu_src_b  = 2'b10;
        alu_op     = 2'b11;
        next_state = WB_I;
      end

      WB_I: begin
        reg_write  = 1'b1;
        retire     = 1'b1;
        next_state = FETCH;
      end

      BRANCH: begin
        alu_src_a     = 1'b1;
        alu_op        = 2'b01;
        pc_write_cond = 1'b1;
        pc_source     = 2'b01;
        branch_ne     = (opcode == OP_BNE);
        retire        = 1'b1;
        next_state    = FETCH;
      end

      JUMP: begin
        pc_write  = 1'b1;
        pc_source = 2'b10;
        // jal links to r31; PC already holds PC+4 from FETCH.
        if (opcode == OP_JAL) begin
          reg_write  = 1'b1;
          reg_dst    = 2'b10;
          mem_to_reg = 2'b10;
        end
        retire     = 1'b1;
        next_state = FETCH;
      end

      TRAP: halted = 1'b1;

      default: next_state = IDLE;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_mips_multicycle_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_mips_multicycle_ctrl
// Purpose  : Self-checking bench for mips_multicycle_ctrl. Each cycle the
//            expected state and control word are queued when inputs are
//            driven, then popped and compared on the falling edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mips_multicycle_ctrl;

  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          nrst = 1'b0;
  logic [5:0]    opcode = 6'd0;
  logic          ir_write, pc_write, pc_write_cond, branch_ne;
  logic [1:0]    pc_source, alu_src_b, alu_op, reg_dst, mem_to_reg;
  logic          alu_src_a, reg_write, halted, bus_error, illegal_op;
  logic [CW-1:0] instr_count;
  logic [3:0]    state_dbg;

  mips_multicycle_ctrl_if mem_if ();

  mips_multicycle_ctrl #(.MEM_TIMEOUT(16), .CNT_W(CW)) dut (
    .clk           (clk),
    .nrst          (nrst),
    .opcode        (opcode),
    .mem           (mem_if),
    .ir_write      (ir_write),
    .pc_write      (pc_write),
    .pc_write_cond (pc_write_cond),
    .branch_ne     (branch_ne),
    .pc_source     (pc_source),
    .alu_src_a     (alu_src_a),
    .alu_src_b     (alu_src_b),
    .alu_op        (alu_op),
    .reg_write     (reg_write),
    .reg_dst       (reg_dst),
    .mem_to_reg    (mem_to_reg),
    .halted        (halted),
    .bus_error     (bus_error),
    .illegal_op    (illegal_op),
    .instr_count   (instr_count),
    .state_dbg     (state_dbg)
  );

  always #5 clk = ~clk;

  // {mem_req, mem_we, iord, ir_write, pc_write, pc_write_cond, branch_ne,
  //  pc_source, alu_src_a, alu_src_b, alu_op, reg_write, reg_dst, mem_to_reg, halted}
  logic [19:0] obs_ctl;
  assign obs_ctl = {mem_if.mem_req, mem_if.mem_we, mem_if.iord, ir_write, pc_write,
                    pc_write_cond, branch_ne, pc_source, alu_src_a, alu_src_b, alu_op,
                    reg_write, reg_dst, mem_to_reg, halted};

  typedef struct {
    string       tag;
    logic [3:0]  st;
    logic [19:0] ctl;
  } exp_t;

  exp_t    sb[$];
  int      n_tests = 0;
  int      n_fail  = 0;
  logic [CW-1:0] exp_cnt = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Expected control word for a state, written straight from the state table.
  function automatic logic [19:0] exp_ctl(input logic [3:0] st, input logic [5:0] op, input logic rdy);
    logic req, we, io, irw, pcw, pwc, bne, sa, rw, hlt;
    logic [1:0] psrc, sb2, aop, dst, m2r;
    {req, we, io, irw, pcw, pwc, bne, sa, rw, hlt} = '0;
    {psrc, sb2, aop, dst, m2r} = '0;
    case (st)
      4'd1:  begin req = 1; sb2 = 2'b01; irw = rdy; pcw = rdy; end
      4'd2:  sb2 = 2'b11;
      4'd3:  begin sa = 1; sb2 = 2'b10; end
      4'd4:  begin req = 1; io = 1; end
      4'd5:  begin rw = 1; m2r = 2'b01; end
      4'd6:  begin req = 1; we = 1; io = 1; end
      4'd7:  begin sa = 1; aop = 2'b10; end
      4'd8:  begin rw = 1; dst = 2'b01; end
      4'd9:  begin sa = 1; sb2 = 2'b10; aop = 2'b11; end
      4'd10: rw = 1;
      4'd11: begin sa = 1; aop = 2'b01; pwc = 1; psrc = 2'b01; bne = (op == 6'b000101); end
      4'd12: begin
        pcw = 1; psrc = 2'b10;
        if (op == 6'b000011) begin rw = 1; dst = 2'b10; m2r = 2'b10; end
      end
      4'd15: hlt = 1;
      default: ;
    endcase
    return {req, we, io, irw, pcw, pwc, bne, psrc, sa, sb2, aop, rw, dst, m2r, hlt};
  endfunction

  task automatic expect_st(input string tag, input logic [3:0] st);
    exp_t e;
    e.tag = tag;
    e.st  = st;
    e.ctl = exp_ctl(st, opcode, mem_if.mem_ready);
    sb.push_back(e);
  endtask

  // Compare everything queued for this cycle, then advance one clock.
  task automatic tick();
    exp_t e;
    @(negedge clk);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      check({e.tag, "_state"}, 32'(state_dbg), 32'(e.st));
      check({e.tag, "_ctl"}, 32'(obs_ctl), 32'(e.ctl));
    end
    @(posedge clk);
    #1;
  endtask

  // Run one instruction with zero-wait memory; sts holds state encodings,
  // first state in the low nibble.
  task automatic run_seq(input string tag, input logic [5:0] op, input int n, input logic [31:0] sts);
    opcode = op;
    mem_if.mem_ready = 1'b1;
    for (int i = 0; i < n; i++) begin
      expect_st(tag, sts[4*i +: 4]);
      tick();
    end
    exp_cnt = exp_cnt + 1'b1;
    check({tag, "_count"}, 32'(instr_count), 32'(exp_cnt));
  endtask

  initial begin
    mem_if.mem_ready = 1'b1;
    nrst = 1'b0;
    @(posedge clk);
    #1;

    // Reset held two cycles, then release
    expect_st("rst0", 4'd0); tick();
    expect_st("rst1", 4'd0); tick();
    check("rst_count", 32'(instr_count), 32'd0);
    check("rst_buserr", 32'(bus_error), 32'd0);
    check("rst_illegal", 32'(illegal_op), 32'd0);
    nrst = 1'b1;
    expect_st("rel_idle", 4'd0); tick();

    // Zero-wait instruction mix
    run_seq("rtype", 6'b000000, 4, 32'h8721);
    run_seq("lw",    6'b100011, 5, 32'h54321);
    check("count_after_r_lw", 32'(instr_count), 32'd2);

    // sw with three wait cycles in MEM_WRITE
    opcode = 6'b101011;
    mem_if.mem_ready = 1'b1;
    expect_st("sw", 4'd1); tick();
    expect_st("sw", 4'd2); tick();
    expect_st("sw", 4'd3); tick();
    mem_if.mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      expect_st("sw_wait", 4'd6); tick();
      check("sw_wait_count", 32'(instr_count), 32'(exp_cnt));
    end
    mem_if.mem_ready = 1'b1;
    expect_st("sw_done", 4'd6); tick();
    exp_cnt = exp_cnt + 1'b1;
    check("sw_count", 32'(instr_count), 32'(exp_cnt));

    run_seq("beq",  6'b000100, 3, 32'hB21);
    run_seq("bne",  6'b000101, 3, 32'hB21);
    run_seq("jal",  6'b000011, 3, 32'hC21);
    run_seq("j",    6'b000010, 3, 32'hC21);
    run_seq("addi", 6'b001000, 4, 32'hA921);
    run_seq("ori",  6'b001101, 4, 32'hA921);

    // Enough jumps to carry the narrow counter through its wrap
    for (int i = 0; i < 10; i++) run_seq("jwrap", 6'b000010, 3, 32'hC21);
    check("count_wrapped", 32'(instr_count), 32'd3);

    // Fetch timeout: 16 un-acknowledged cycles trap with bus_error
    mem_if.mem_ready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (i == 15) check("tmo_pre_buserr", 32'(bus_error), 32'd0);
      expect_st("tmo_wait", 4'd1); tick();
    end
    check("tmo_buserr", 32'(bus_error), 32'd1);
    expect_st("tmo_trap", 4'd15); tick();
    mem_if.mem_ready = 1'b1;
    expect_st("tmo_trap_hold", 4'd15); tick();

    nrst = 1'b0;
    expect_st("tmo_rst", 4'd15); tick();
    check("tmo_rst_buserr", 32'(bus_error), 32'd0);
    check("tmo_rst_count", 32'(instr_count), 32'd0);
    exp_cnt = '0;
    nrst = 1'b1;
    expect_st("tmo2_idle", 4'd0); tick();

    // mem_ready on the 16th cycle wins over the timeout
    mem_if.mem_ready = 1'b0;
    for (int i = 0; i < 15; i++) begin
      expect_st("tmo2_wait", 4'd1); tick();
    end
    mem_if.mem_ready = 1'b1;
    opcode = 6'b111111;
    expect_st("tmo2_last", 4'd1); tick();
    check("tmo2_buserr", 32'(bus_error), 32'd0);

    // Illegal opcode traps; inputs ignored while halted
    expect_st("ill_decode", 4'd2); tick();
    check("ill_flag", 32'(illegal_op), 32'd1);
    for (int i = 0; i < 4; i++) begin
      mem_if.mem_ready = i[0];
      opcode = 6'($urandom_range(0, 63));
      expect_st("ill_trap", 4'd15); tick();
    end
    nrst = 1'b0;
    expect_st("ill_rst", 4'd15); tick();
    check("ill_rst_flag", 32'(illegal_op), 32'd0);

    // Reset in the middle of a waiting load drops mem_req next cycle
    nrst = 1'b1;
    opcode = 6'b100011;
    mem_if.mem_ready = 1'b1;
    expect_st("mid_idle", 4'd0); tick();
    expect_st("mid", 4'd1); tick();
    expect_st("mid", 4'd2); tick();
    expect_st("mid", 4'd3); tick();
    mem_if.mem_ready = 1'b0;
    expect_st("mid_wait", 4'd4); tick();
    nrst = 1'b0;
    expect_st("mid_wait_rst", 4'd4); tick();
    expect_st("mid_after_rst", 4'd0); tick();
    check("mid_count", 32'(instr_count), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mips_multicycle_ctrl.md
Name: mips_multicycle_ctrl

Overview:
Moore-style sequencing controller for the multi-cycle variant of the MIPS datapath, which uses a single shared instruction/data memory, an instruction register (IR) and one ALU reused across cycles. It steps each instruction through fetch, decode, execute, memory and writeback. It drives every datapath select and enable, and holds a request/ready handshake with the shared memory. It also counts retired instructions and traps on illegal opcodes or memory timeout.

Parameters:
MEM_TIMEOUT, 16, number of consecutive un-acknowledged mem_req cycles before bus_error; 0 disables the timeout.
CNT_W, 32, width of the retired-instruction counter.

Ports:
clk  in  1  clock, all state updates on rising edge
nrst  in  1  synchronous active-low reset
opcode  in  6  IR[31:26]; valid from DECODE onward
mem_ready  in  1  memory completes the current access this cycle
mem_req  out  1  memory access request
mem_we  out  1  write access (valid only with mem_req)
iord  out  1  address select: 0 = PC, 1 = ALUOut
ir_write  out  1  load IR from memory read data
pc_write  out  1  unconditional PC load
pc_write_cond  out  1  PC load if the branch condition holds
branch_ne  out  1  branch condition: 0 = ALU zero, 1 = not zero
pc_source  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target
alu_src_a  out  1  0 = PC, 1 = register A
alu_src_b  out  2  00 = register B, 01 = constant 4, 10 = sign-extended immediate, 11 = sign-extended immediate << 2
alu_op  out  2  00 = add, 01 = sub, 10 = use funct, 11 = opcode-specific immediate op
reg_write  out  1  register bank write enable
reg_dst  out  2  00 = rt, 01 = rd, 10 = r31
mem_to_reg  out  2  00 = ALUOut, 01 = MDR, 10 = PC
halted  out  1  controller is in TRAP
bus_error  out  1  sticky; set on memory timeout
illegal_op  out  1  sticky; set on unknown opcode
instr_count  out  CNT_W  retired-instruction count, wraps
state_dbg  out  4  current state encoding

Behaviour:
- Reset: nrst=0 at a clk edge forces state to IDLE and clears instr_count, timeout counter, bus_error and illegal_op. In IDLE all outputs are 0.
- Reset mid-access drops mem_req on the cycle after the edge. No partial writeback occurs.
- Outputs decode from the state register only, except that ir_write and pc_write in FETCH are qualified by mem_ready. Every output not listed for a state is 0.
- State encodings: IDLE=0, FETCH=1, DECODE=2, MEM_ADDR=3, MEM_READ=4, MEM_WB=5, MEM_WRITE=6, EXEC_R=7, WB_R=8, EXEC_I=9, WB_I=10, BRANCH=11, JUMP=12, TRAP=15.
- IDLE: advance to FETCH unconditionally on the next cycle.
- FETCH: mem_req=1, iord=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_source=00, ir_write=pc_write=mem_ready. Stay until mem_ready=1, then go to DECODE.
- DECODE: alu_src_a=0, alu_src_b=11, alu_op=00 (branch target into ALUOut). Next state by opcode:
  - 000000 -> EXEC_R
  - 100011 lw / 101011 sw -> MEM_ADDR
  - 000100 beq / 000101 bne -> BRANCH
  - 000010 j / 000011 jal -> JUMP
  - 001000 addi, 001100 andi, 001101 ori, 001010 slti -> EXEC_I
  - any other opcode -> TRAP, with illegal_op set.
- MEM_ADDR: alu_src_a=1, alu_src_b=10, alu_op=00. lw -> MEM_READ, sw -> MEM_WRITE.
- MEM_READ: mem_req=1, iord=1. Wait for mem_ready, then go to MEM_WB.
- MEM_WB: reg_write=1, reg_dst=00, mem_to_reg=01. Retire, then FETCH.
- MEM_WRITE: mem_req=1, mem_we=1, iord=1. Wait for mem_ready, then retire and go to FETCH.
- EXEC_R: alu_src_a=1, alu_src_b=00, alu_op=10, then WB_R.
- WB_R: reg_write=1, reg_dst=01, mem_to_reg=00. Retire, then FETCH.
- EXEC_I: alu_src_a=1, alu_src_b=10, alu_op=11, then WB_I.
- WB_I: reg_write=1, reg_dst=00, mem_to_reg=00. Retire, then FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond=1, pc_source=01, branch_ne=(opcode==000101). Retire, then FETCH.
- JUMP: pc_write=1, pc_source=10. For jal also reg_write=1, reg_dst=10, mem_to_reg=10 (PC already holds PC+4). Retire, then FETCH.
- Retire: instr_count increments by 1 on the final-state cycle and wraps from 2^CNT_W-1 to 0.
- Latency with zero-wait memory (cycles from entering FETCH to re-entering FETCH):
  - R-type, I-type ALU, sw: 4
  - lw: 5
  - beq, bne, j, jal: 3
  - each memory wait cycle adds 1.
- Timeout: the counter increments each cycle in FETCH, MEM_READ or MEM_WRITE while mem_ready=0, and clears on mem_ready or on leaving those states.
  - When the count reaches MEM_TIMEOUT (nonzero) without mem_ready, set bus_error and go to TRAP next cycle.
  - mem_ready=1 in the same cycle the limit is reached wins: the access completes normally.
- mem_ready outside FETCH, MEM_READ and MEM_WRITE is ignored.
- TRAP: all datapath outputs 0, halted=1. Held until reset; opcode and mem_ready are ignored.

Test Plan:
- Reset sequence: nrst=0 for 2 cycles, then 1 -> state_dbg=0 with all outputs 0 while nrst=0; FETCH (state_dbg=1) with mem_req=1 one cycle after release.
- R-type then lw, zero-wait (mem_ready tied 1) -> R-type states 1,2,7,8; lw states 1,2,3,4,5; instr_count=2 after 9 cycles; reg_dst=01 in WB_R and mem_to_reg=01 in MEM_WB.
- sw with 3 wait cycles in MEM_WRITE -> mem_req=mem_we=iord=1 held exactly 4 cycles; instr_count increments once, on the mem_ready cycle.
- beq then bne then jal -> pc_write_cond=1 with branch_ne 0 then 1; in JUMP, pc_write=1, pc_source=10, reg_write=1, reg_dst=10, mem_to_reg=10; each instruction takes 3 cycles.
- Opcode 111111 in DECODE -> TRAP next cycle with illegal_op=1 and halted=1; mem_ready toggling has no effect; nrst=0 clears to IDLE.
- MEM_TIMEOUT=16, mem_ready=0 in FETCH -> bus_error=1 and TRAP after 16 wait cycles. Repeat with mem_ready=1 on the 16th cycle -> normal DECODE, bus_error=0.
